// File: rtl/escalonador_medidor.sv
// Round-robin scheduler sharing one ultrasonic range-measurement datapath among N_REQ requesters.
// Starts a measurement, waits for the result or a timeout, acks the requester, then holds a guard interval.
module escalonador_medidor #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned IDX_W       = 2,
  parameter int unsigned MED_W       = 12,
  parameter int unsigned TIMEOUT_CYC = 2_500_000,
  parameter int unsigned GUARD_CYC   = 500_000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             pronto_medida,
  input  logic [MED_W-1:0] medida,
  output logic [IDX_W-1:0] sel,
  output logic             mensurar,
  output logic [N_REQ-1:0] ack,
  output logic [MED_W-1:0] dado,
  output logic [IDX_W-1:0] dado_id,
  output logic             dado_valido,
  output logic             erro_timeout,
  output logic             ocupado,
  output logic [3:0]       db_estado
);

  localparam int unsigned TMR_MAX = (TIMEOUT_CYC > GUARD_CYC) ? TIMEOUT_CYC : GUARD_CYC;
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int unsigned SUM_W   = IDX_W + 1;
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] GRD_LAST = TMR_W'(GUARD_CYC - 1);

  typedef enum logic [3:0] {
    OCIOSO    = 4'b0000,
    SELECIONA = 4'b0001,
    ENVIA     = 4'b0010,
    AGUARDA   = 4'b0011,
    REGISTRA  = 4'b0100,
    FALHA     = 4'b0101,
    GUARDA    = 4'b0110
  } estado_e;

  estado_e          state_q, state_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [MED_W-1:0] dado_q, dado_d;
  logic [IDX_W-1:0] dado_id_q, dado_id_d;

  logic             grant_vld;
  logic [IDX_W-1:0] grant_idx;
  logic [SUM_W-1:0] sum_c;

  // Round-robin pick: first active request after the last served index.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    sum_c     = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      sum_c = {1'b0, ptr_q} + SUM_W'(k);
      if (sum_c >= SUM_W'(N_REQ)) begin
        sum_c = sum_c - SUM_W'(N_REQ);
      end
      if (!grant_vld && req[sum_c[IDX_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = sum_c[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= OCIOSO;
      sel_q     <= '0;
      ptr_q     <= IDX_W'(N_REQ - 1);
      timer_q   <= '0;
      dado_q    <= '0;
      dado_id_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      timer_q   <= timer_d;
      dado_q    <= dado_d;
      dado_id_q <= dado_id_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    timer_d   = timer_q;
    dado_d    = dado_q;
    dado_id_d = dado_id_q;
    case (state_q)
      OCIOSO: begin
        if (|req) state_d = SELECIONA;
      end
      SELECIONA: begin
        timer_d = '0;
        if (grant_vld) begin
          sel_d   = grant_idx;
          state_d = ENVIA;
        end else begin
          // Request withdrawn before the grant: nothing to serve.
          state_d = OCIOSO;
        end
      end
      ENVIA: begin
        state_d = AGUARDA;
      end
      AGUARDA: begin
        // A result on the final timeout cycle still counts as valid.
        if (pronto_medida) begin
          dado_d    = medida;
          dado_id_d = sel_q;
          timer_d   = '0;
          state_d   = REGISTRA;
        end else if (timer_q == TMO_LAST) begin
          timer_d = '0;
          state_d = FALHA;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      REGISTRA, FALHA: begin
        ptr_d   = sel_q;
        timer_d = '0;
        state_d = GUARDA;
      end
      GUARDA: begin
        if (timer_q == GRD_LAST) begin
          timer_d = '0;
          state_d = OCIOSO;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = OCIOSO;
      end
    endcase
  end

  // Pulses and status decoded directly from the state register.
  always_comb begin
    mensurar     = (state_q == ENVIA);
    dado_valido  = (state_q == REGISTRA);
    erro_timeout = (state_q == FALHA);
    ocupado      = (state_q != OCIOSO);
    ack          = '0;
    if ((state_q == REGISTRA) || (state_q == FALHA)) begin
      ack = N_REQ'(1) << sel_q;
    end
    case (state_q)
      OCIOSO, SELECIONA, ENVIA, AGUARDA,
      REGISTRA, FALHA, GUARDA: db_estado = state_q;
      default:                 db_estado = 4'b1111;
    endcase
  end

  assign sel     = sel_q;
  assign dado    = dado_q;
  assign dado_id = dado_id_q;

endmodule

// File: tb/tb_escalonador_medidor.sv
// Directed bench for escalonador_medidor: a table of measurement transactions plus
// hand sequences for reset mid-measurement, stray pronto pulses and withdrawn requests.
module tb_escalonador_medidor;

  localparam int unsigned TMO = 50;
  localparam int unsigned GRD = 10;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic        pronto_medida;
  logic [11:0] medida;
  logic [1:0]  sel;
  logic        mensurar;
  logic [3:0]  ack;
  logic [11:0] dado;
  logic [1:0]  dado_id;
  logic        dado_valido;
  logic        erro_timeout;
  logic        ocupado;
  logic [3:0]  db_estado;

  escalonador_medidor #(
    .N_REQ(4), .IDX_W(2), .MED_W(12), .TIMEOUT_CYC(TMO), .GUARD_CYC(GRD)
  ) dut (
    .clock(clock), .reset(reset), .req(req), .pronto_medida(pronto_medida),
    .medida(medida), .sel(sel), .mensurar(mensurar), .ack(ack), .dado(dado),
    .dado_id(dado_id), .dado_valido(dado_valido), .erro_timeout(erro_timeout),
    .ocupado(ocupado), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  req;
    int          pronto_at;   // AGUARDA cycle carrying pronto; 0 = never
    logic [11:0] medida;
    logic        hold;        // keep the whole req vector high after ack
    logic        guard_pronto;
    logic [1:0]  exp_sel;
    logic [3:0]  exp_ack;
    logic        exp_valid;
    logic [11:0] exp_dado;
    logic [1:0]  exp_id;
  } txn_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_ack_cyc = 0;
  bit have_prev = 0;
  txn_t tab [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic run_txn(input txn_t v);
    int  n;
    int  c;
    int  g;
    int  exp_c;
    bit  seen;
    bit  stray;
    chk("idle_before", 32'(db_estado), 32'h0);
    req  = v.req;
    n    = 0;
    seen = 0;
    while (!seen && n < 10) begin
      step();
      n++;
      if (mensurar) seen = 1;
    end
    chk("mensurar_latency", 32'(n), 32'd2);
    chk("sel", 32'(sel), 32'(v.exp_sel));
    chk("ocupado_busy", 32'(ocupado), 32'h1);
    if (have_prev) chk("service_gap", 32'(cyc - last_ack_cyc - 1), 32'(GRD + 2));
    step();
    chk("mensurar_width", 32'(mensurar), 32'h0);
    chk("estado_aguarda", 32'(db_estado), 32'h3);
    c    = 0;
    seen = 0;
    while (!seen && c < 200) begin
      c++;
      if (c == v.pronto_at) begin
        pronto_medida = 1'b1;
        medida        = v.medida;
      end
      step();
      pronto_medida = 1'b0;
      medida        = 12'hBAD;
      if (ack != 4'h0) seen = 1;
    end
    exp_c = (v.pronto_at == 0) ? int'(TMO) : v.pronto_at;
    chk("aguarda_cycles", 32'(c), 32'(exp_c));
    chk("ack", 32'(ack), 32'(v.exp_ack));
    chk("dado_valido", 32'(dado_valido), 32'(v.exp_valid));
    chk("erro_timeout", 32'(erro_timeout), 32'(!v.exp_valid));
    chk("dado", 32'(dado), 32'(v.exp_dado));
    chk("dado_id", 32'(dado_id), 32'(v.exp_id));
    chk("estado_end", 32'(db_estado), v.exp_valid ? 32'h4 : 32'h5);
    last_ack_cyc = cyc;
    have_prev    = 1;
    req = v.hold ? v.req : (v.req & ~v.exp_ack);
    step();
    chk("ack_width", 32'(ack), 32'h0);
    chk("pulse_width", 32'({dado_valido, erro_timeout}), 32'h0);
    g     = 0;
    stray = 0;
    while (db_estado == 4'h6 && g < 100) begin
      g++;
      if (v.guard_pronto && g == 5) begin
        pronto_medida = 1'b1;
        medida        = 12'hEEE;
      end
      step();
      pronto_medida = 1'b0;
      if (ack != 4'h0 || dado_valido) stray = 1;
    end
    chk("guard_len", 32'(g), 32'(GRD));
    chk("guard_no_ack", 32'(stray), 32'h0);
    chk("ocioso_after", 32'(ocupado), 32'h0);
    chk("dado_hold", 32'(dado), 32'(v.exp_dado));
  endtask

  initial begin
    int  n;
    bit  seen;
    txn_t t;

    //        req    p   medida hold gp sel ack   val dado    id
    tab[0] = '{4'h1, 20, 12'h0A5, 1'b0, 1'b0, 2'd0, 4'h1, 1'b1, 12'h0A5, 2'd0};
    tab[1] = '{4'hF,  3, 12'h111, 1'b1, 1'b0, 2'd1, 4'h2, 1'b1, 12'h111, 2'd1};
    tab[2] = '{4'hF,  4, 12'h222, 1'b1, 1'b0, 2'd2, 4'h4, 1'b1, 12'h222, 2'd2};
    tab[3] = '{4'hF,  5, 12'h333, 1'b1, 1'b0, 2'd3, 4'h8, 1'b1, 12'h333, 2'd3};
    tab[4] = '{4'hF,  6, 12'h344, 1'b1, 1'b0, 2'd0, 4'h1, 1'b1, 12'h344, 2'd0};
    tab[5] = '{4'h4,  0, 12'h000, 1'b0, 1'b0, 2'd2, 4'h4, 1'b0, 12'h344, 2'd0};
    tab[6] = '{4'h2, 50, 12'h123, 1'b0, 1'b0, 2'd1, 4'h2, 1'b1, 12'h123, 2'd1};
    tab[7] = '{4'h2,  5, 12'h456, 1'b0, 1'b1, 2'd1, 4'h2, 1'b1, 12'h456, 2'd1};

    reset = 1'b1;
    req = 4'h0;
    pronto_medida = 1'b0;
    medida = 12'h0;
    repeat (3) step();
    reset = 1'b0;
    chk("rst_estado", 32'(db_estado), 32'h0);
    chk("rst_outputs", 32'({sel, mensurar, ack, dado_valido, erro_timeout, ocupado}), 32'h0);
    chk("rst_dado", 32'({dado, dado_id}), 32'h0);

    for (int i = 0; i < 8; i++) run_txn(tab[i]);

    // Request withdrawn while still in SELECIONA is not served.
    req = 4'h1;
    step();
    req = 4'h0;
    step();
    chk("drop_back_idle", 32'(db_estado), 32'h0);
    seen = 0;
    repeat (4) begin
      step();
      if (mensurar || ack != 4'h0) seen = 1;
    end
    chk("drop_not_served", 32'(seen), 32'h0);

    // Stray pronto while idle.
    pronto_medida = 1'b1;
    medida = 12'hFFF;
    step();
    pronto_medida = 1'b0;
    chk("idle_pronto_state", 32'(db_estado), 32'h0);
    chk("idle_pronto_dado", 32'(dado), 32'h456);
    chk("idle_pronto_pulses", 32'({ack, dado_valido}), 32'h0);

    // Reset in the middle of AGUARDA; pointer must restart so index 0 wins.
    req = 4'h5;
    n = 0;
    while (db_estado != 4'h3 && n < 10) begin
      step();
      n++;
    end
    chk("reach_aguarda", 32'(db_estado), 32'h3);
    repeat (3) step();
    reset = 1'b1;
    step();
    chk("mid_rst_estado", 32'(db_estado), 32'h0);
    chk("mid_rst_outputs", 32'({sel, mensurar, ack, dado_valido, erro_timeout, ocupado}), 32'h0);
    chk("mid_rst_dado", 32'({dado, dado_id}), 32'h0);
    reset = 1'b0;
    have_prev = 0;
    t = '{4'h5, 4, 12'h0AA, 1'b0, 1'b0, 2'd0, 4'h1, 1'b1, 12'h0AA, 2'd0};
    run_txn(t);
    t = '{4'h4, 7, 12'h0BB, 1'b0, 1'b0, 2'd2, 4'h4, 1'b1, 12'h0BB, 2'd2};
    run_txn(t);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
